// File: rtl/vga_sync_gen_if.sv
// ----------------------------------------------------------------------------
// vga_sync_gen_if
// Raster timing bundle from vga_sync_gen to the tile-mask stage.
//   pix_en    : one-clk strobe; the raster counters advance on this cycle
//   xCount    : horizontal pixel counter, 0..H_TOTAL-1
//   yCount    : vertical line counter, 0..V_TOTAL-1
//   visible   : high inside the active picture area
//   hsync     : active-low horizontal sync
//   vsync     : active-low vertical sync
//   update    : one-pixel frame pulse at the start of vertical blanking
//   frame_cnt : frame counter (zero unless VGA_FRAME_CNT_EN is defined)
// master = timing generator, slave = consumer.
// ----------------------------------------------------------------------------
interface vga_sync_gen_if;
    logic       pix_en;
    logic [9:0] xCount;
    logic [9:0] yCount;
    logic       visible;
    logic       hsync;
    logic       vsync;
    logic       update;
    logic [7:0] frame_cnt;

    modport master (
        output pix_en, xCount, yCount, visible, hsync, vsync, update, frame_cnt
    );

    modport slave (
        input pix_en, xCount, yCount, visible, hsync, vsync, update, frame_cnt
    );
endinterface

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
// VGA raster timing generator (640x480@60 Hz from 50 MHz with defaults).
// A clock divider produces the pixel strobe; x/y counters walk the raster and
// all sync/visible/update outputs are decoded from the next-state counter
// values so they are registered on the same edge as the counters and always
// describe the current xCount/yCount.
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   vga : vga_sync_gen_if.master (pix_en, xCount, yCount, visible, hsync,
//         vsync, update, frame_cnt)
//
// Optional feature: define VGA_FRAME_CNT_EN to enable the 8-bit frame counter
// (increments when update rises). Without it frame_cnt is tied to zero.
// ----------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // CLK_DIV=1 would give a zero-width divider; keep at least one bit.
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             visible_q, visible_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             update_q, update_d;

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        // Strobe is registered, so it is high in the cycle after the divider
        // reaches its last count; with CLK_DIV=1 it stays high.
        pix_en_d = (div_q == DIV_LAST);

        x_d = x_q;
        y_d = y_q;
        if (pix_en_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        // Decode from next-state counters so outputs line up with them.
        visible_d = (x_d < H_ACT_L) && (y_d < V_ACT_L);
        hsync_d   = !((x_d >= HS_START) && (x_d < HS_END));
        vsync_d   = !((y_d >= VS_START) && (y_d < VS_END));
        update_d  = (x_d == '0) && (y_d == V_ACT_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            pix_en_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            visible_q <= 1'b1;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            update_q  <= 1'b0;
        end else begin
            div_q     <= div_d;
            pix_en_q  <= pix_en_d;
            x_q       <= x_d;
            y_q       <= y_d;
            visible_q <= visible_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            update_q  <= update_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_q, frame_d;

    always_comb begin
        frame_d = frame_q;
        if (update_d && !update_q) begin
            frame_d = frame_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign vga.frame_cnt = frame_q;
`else
    assign vga.frame_cnt = 8'd0;
`endif

    assign vga.pix_en  = pix_en_q;
    assign vga.xCount  = x_q;
    assign vga.yCount  = y_q;
    assign vga.visible = visible_q;
    assign vga.hsync   = hsync_q;
    assign vga.vsync   = vsync_q;
    assign vga.update  = update_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_gen
// Two instances share clk/rst: a small raster with CLK_DIV=1 (fast frames,
// frame counter wrap) and the default 640x480 raster with CLK_DIV=2 (real
// hsync positions). The expected outputs are derived from the number of
// clock edges since reset release: pixel steps = edges / CLK_DIV, raster
// position = steps mod (H_TOTAL*V_TOTAL).
// ----------------------------------------------------------------------------
module tb_vga_sync_gen;

    typedef struct packed {
        logic       pe;
        logic [9:0] x;
        logic [9:0] y;
        logic       vis;
        logic       hs;
        logic       vs;
        logic       upd;
        logic [7:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    longint k     = -1;    // edges since reset release, -1 = reset state
    bit     k_ok  = 1'b0;

    vga_sync_gen_if if_s ();
    vga_sync_gen_if if_d ();

    vga_sync_gen #(
        .H_ACTIVE(6), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1)
    ) dut_s (
        .clk(clk),
        .rst(rst),
        .vga(if_s)
    );

    vga_sync_gen dut_d (
        .clk(clk),
        .rst(rst),
        .vga(if_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        k    <= rst ? -64'sd1 : k + 64'sd1;
        k_ok <= 1'b1;
    end

    function automatic exp_t model(longint kk, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, int d);
        exp_t   e;
        longint steps, ht, vt, p, first, frames;
        ht    = ha + hf + hs + hb;
        vt    = va + vf + vs + vb;
        steps = (kk < 0) ? 0 : kk / d;
        p     = steps % (ht * vt);
        e.pe  = (kk >= 0) && ((kk % d) == d - 1);
        e.x   = 10'(p % ht);
        e.y   = 10'(p / ht);
        e.vis = (p % ht < ha) && (p / ht < va);
        e.hs  = !((p % ht >= ha + hf) && (p % ht < ha + hf + hs));
        e.vs  = !((p / ht >= va + vf) && (p / ht < va + vf + vs));
        e.upd = (p % ht == 0) && (p / ht == va);
        first = va * ht;
        frames = (steps >= first) ? (steps - first) / (ht * vt) + 1 : 0;
`ifdef VGA_FRAME_CNT_EN
        e.fc  = 8'(frames % 256);
`else
        e.fc  = 8'd0;
`endif
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s at k=%0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t a, input exp_t e);
        cmp({tag, ".pix_en"},    32'(a.pe),  32'(e.pe));
        cmp({tag, ".xCount"},    32'(a.x),   32'(e.x));
        cmp({tag, ".yCount"},    32'(a.y),   32'(e.y));
        cmp({tag, ".visible"},   32'(a.vis), 32'(e.vis));
        cmp({tag, ".hsync"},     32'(a.hs),  32'(e.hs));
        cmp({tag, ".vsync"},     32'(a.vs),  32'(e.vs));
        cmp({tag, ".update"},    32'(a.upd), 32'(e.upd));
        cmp({tag, ".frame_cnt"}, 32'(a.fc),  32'(e.fc));
    endtask

    function automatic exp_t act_s();
        return {if_s.pix_en, if_s.xCount, if_s.yCount, if_s.visible,
                if_s.hsync, if_s.vsync, if_s.update, if_s.frame_cnt};
    endfunction

    function automatic exp_t act_d();
        return {if_d.pix_en, if_d.xCount, if_d.yCount, if_d.visible,
                if_d.hsync, if_d.vsync, if_d.update, if_d.frame_cnt};
    endfunction

    // Continuous check of both instances against the model, away from the edge.
    always @(negedge clk) begin
        if (k_ok) begin
            cmp_all("small", act_s(), model(k, 6, 2, 2, 2, 4, 1, 2, 1, 1));
            cmp_all("dflt",  act_d(), model(k, 640, 16, 96, 48, 480, 10, 2, 33, 2));
        end
    end

    // Hand-computed expectations at known edge counts after a reset release.
    task automatic directed(input int i);
        case (i)
            0: begin
                cmp("lit.s.pe0", 32'(if_s.pix_en), 32'd1);
                cmp("lit.d.pe0", 32'(if_d.pix_en), 32'd0);
            end
            1: cmp("lit.d.pe1", 32'(if_d.pix_en), 32'd1);
            2: begin
                cmp("lit.d.x2",  32'(if_d.xCount), 32'd1);
                cmp("lit.d.pe2", 32'(if_d.pix_en), 32'd0);
            end
            8:  cmp("lit.s.hs8",  32'(if_s.hsync), 32'd0);
            10: cmp("lit.s.hs10", 32'(if_s.hsync), 32'd1);
            47: begin
                cmp("lit.s.x47",   32'(if_s.xCount), 32'd11);
                cmp("lit.s.upd47", 32'(if_s.update), 32'd0);
            end
            48: begin
                cmp("lit.s.x48",   32'(if_s.xCount), 32'd0);
                cmp("lit.s.y48",   32'(if_s.yCount), 32'd4);
                cmp("lit.s.upd48", 32'(if_s.update), 32'd1);
                cmp("lit.s.vis48", 32'(if_s.visible), 32'd0);
            end
            49: cmp("lit.s.upd49", 32'(if_s.update), 32'd0);
            60: cmp("lit.s.vs60",  32'(if_s.vsync), 32'd0);
            84: cmp("lit.s.vs84",  32'(if_s.vsync), 32'd1);
            95: begin
                cmp("lit.s.x95", 32'(if_s.xCount), 32'd11);
                cmp("lit.s.y95", 32'(if_s.yCount), 32'd7);
            end
            96: begin
                cmp("lit.s.x96",   32'(if_s.xCount), 32'd0);
                cmp("lit.s.y96",   32'(if_s.yCount), 32'd0);
                cmp("lit.s.vis96", 32'(if_s.visible), 32'd1);
            end
            1279: cmp("lit.d.vis639", 32'(if_d.visible), 32'd1);
            1280: begin
                cmp("lit.d.x640",   32'(if_d.xCount), 32'd640);
                cmp("lit.d.vis640", 32'(if_d.visible), 32'd0);
            end
            1311: cmp("lit.d.hs655", 32'(if_d.hsync), 32'd1);
            1312: cmp("lit.d.hs656", 32'(if_d.hsync), 32'd0);
            1503: cmp("lit.d.hs751", 32'(if_d.hsync), 32'd0);
            1504: cmp("lit.d.hs752", 32'(if_d.hsync), 32'd1);
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst.s.x",   32'(if_s.xCount),  32'd0);
        cmp("rst.s.pe",  32'(if_s.pix_en),  32'd0);
        cmp("rst.s.vis", 32'(if_s.visible), 32'd1);
        cmp("rst.d.y",   32'(if_d.yCount),  32'd0);
        cmp("rst.d.hs",  32'(if_d.hsync),   32'd1);
        cmp("rst.d.vs",  32'(if_d.vsync),   32'd1);
        cmp("rst.d.upd", 32'(if_d.update),  32'd0);
        cmp("rst.s.fc",  32'(if_s.frame_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 1600; i++) begin
            @(posedge clk);
            #1;
            directed(i);
        end

        // Random mid-frame resets of random length.
        for (int s = 0; s < 15; s++) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat ($urandom_range(50, 2500)) @(posedge clk);
            #1;
        end

        // Long uninterrupted run: frame counter reaches 3 and wraps past 256.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 24700; i++) begin
            @(posedge clk);
            #1;
`ifdef VGA_FRAME_CNT_EN
            if (i == 240)   cmp("lit.s.fc3",   32'(if_s.frame_cnt), 32'd3);
            if (i == 24527) cmp("lit.s.fc255", 32'(if_s.frame_cnt), 32'd255);
            if (i == 24528) cmp("lit.s.fc256", 32'(if_s.frame_cnt), 32'd0);
`else
            if (i == 240)   cmp("lit.s.fc3",   32'(if_s.frame_cnt), 32'd0);
            if (i == 24528) cmp("lit.s.fc256", 32'(if_s.frame_cnt), 32'd0);
`endif
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
